// File: rtl/hazard_md_ctrl_pkg.sv
// Shared types and constants for the MIPS hazard / mult-div sequencing controller.
// Optional stall statistics are enabled in the top by defining HAZARD_MD_STATS_EN.
package hazard_md_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusyMul = 2'd1,
        StBusyDiv = 2'd2
    } md_state_e;

    // A Tuse of 3 marks an operand the D instruction never reads.
    localparam logic [1:0] TUSE_UNUSED = 2'd3;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;
    localparam int unsigned DEF_CNT_W       = 4;

    function automatic int unsigned md_cycles(input logic        is_div,
                                              input int unsigned mult_c,
                                              input int unsigned div_c);
        return is_div ? div_c : mult_c;
    endfunction

endpackage

// File: rtl/hazard_md_ctrl_hazard_cmp.sv
// Single-operand RAW hazard compare: flags a stall when an in-flight E/M writer
// targets this operand and its result arrives later than the D stage needs it.
module hazard_cmp
    import hazard_md_ctrl_pkg::*;
(
    input  logic [4:0] a,
    input  logic [1:0] tuse,
    input  logic [4:0] e_a3,
    input  logic [1:0] e_tnew,
    input  logic       e_we,
    input  logic [4:0] m_a3,
    input  logic [1:0] m_tnew,
    input  logic       m_we,
    output logic       hz
);

    logic used;
    logic hz_e;
    logic hz_m;

    always_comb begin
        // $zero is never a true dependency, and an unused operand cannot hazard.
        used = (tuse != TUSE_UNUSED) && (a != 5'd0);
        hz_e = used && e_we && (e_a3 == a) && (tuse < e_tnew);
        hz_m = used && m_we && (m_a3 == a) && (tuse < m_tnew);
        hz   = hz_e || hz_m;
    end

endmodule

// File: rtl/hazard_md_ctrl.sv
// D-stage stall / D-E bubble control plus the mult/div busy sequencer.
// Define HAZARD_MD_STATS_EN to add the saturating stall_cnt output.
module hazard_md_ctrl
    import hazard_md_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        E_WE,
    input  logic        M_WE,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        flush_E,
    output logic        md_busy,
    output logic        hilo_we
`ifdef HAZARD_MD_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic             hz_rs;
    logic             hz_rt;
    logic             md_hz;
    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;

    hazard_cmp u_cmp_rs (
        .a      (D_A1),
        .tuse   (D_Tuse_rs),
        .e_a3   (E_A3),
        .e_tnew (E_Tnew),
        .e_we   (E_WE),
        .m_a3   (M_A3),
        .m_tnew (M_Tnew),
        .m_we   (M_WE),
        .hz     (hz_rs)
    );

    hazard_cmp u_cmp_rt (
        .a      (D_A2),
        .tuse   (D_Tuse_rt),
        .e_a3   (E_A3),
        .e_tnew (E_Tnew),
        .e_we   (E_WE),
        .m_a3   (M_A3),
        .m_tnew (M_Tnew),
        .m_we   (M_WE),
        .hz     (hz_rt)
    );

    always_comb begin
        md_busy = (state_q != StIdle);
        hilo_we = md_busy && (cnt_q == CNT_W'(1));
        // A start in E occupies the unit next cycle, so HI/LO users in D must wait now.
        md_hz   = D_is_md && (md_busy || E_md_start);
        // Gated by reset_n so every output is low while reset is held.
        stall   = reset_n && (hz_rs || hz_rt || md_hz);
        flush_E = stall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (E_md_start) begin
                        state_q <= E_md_div ? StBusyDiv : StBusyMul;
                        cnt_q   <= CNT_W'(md_cycles(E_md_div, MULT_CYCLES, DIV_CYCLES));
                    end
                end
                StBusyMul, StBusyDiv: begin
                    // A new start while busy is ignored; correct stalling never issues one.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_MD_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Self-checking bench for hazard_md_ctrl: vector table, hand-built mult/div/reset
// sequences, and randomized stimulus against a behavioural model.
module tb_hazard_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] D_A1, D_A2, E_A3, M_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic       D_is_md, E_WE, M_WE, E_md_start, E_md_div;
    logic       stall, flush_E, md_busy, hilo_we;
`ifdef HAZARD_MD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    hazard_md_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .D_A1       (D_A1),
        .D_A2       (D_A2),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_is_md    (D_is_md),
        .E_A3       (E_A3),
        .M_A3       (M_A3),
        .E_Tnew     (E_Tnew),
        .M_Tnew     (M_Tnew),
        .E_WE       (E_WE),
        .M_WE       (M_WE),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .stall      (stall),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
        .hilo_we    (hilo_we)
`ifdef HAZARD_MD_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: remaining busy cycles of the mult/div unit.
    int md_left;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          md_left <= 0;
        else if (md_left > 0)  md_left <= md_left - 1;
        else if (E_md_start)   md_left <= E_md_div ? DC : MC;
    end

    function automatic logic op_hz(input logic [4:0] a, input logic [1:0] tuse);
        int t;
        t = int'(tuse);
        if (tuse == 2'd3 || a == 5'd0) return 1'b0;
        if (E_WE && E_A3 == a && t < int'(E_Tnew)) return 1'b1;
        if (M_WE && M_A3 == a && t < int'(M_Tnew)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_stall();
        if (!reset_n) return 1'b0;
        return op_hz(D_A1, D_Tuse_rs) || op_hz(D_A2, D_Tuse_rt) ||
               (D_is_md && (md_left > 0 || E_md_start));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " stall"},   32'(stall),   32'(model_stall()));
        chk({tag, " flush_E"}, 32'(flush_E), 32'(model_stall()));
        chk({tag, " md_busy"}, 32'(md_busy), 32'(md_left > 0));
        chk({tag, " hilo_we"}, 32'(hilo_we), 32'(md_left == 1));
    endtask

    task automatic clear_inputs();
        D_A1 = 0; D_A2 = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_is_md = 0;
        E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0; E_WE = 0; M_WE = 0;
        E_md_start = 0; E_md_div = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] a1, a2;
        logic [1:0] tuse_rs, tuse_rt;
        logic [4:0] e_a3, m_a3;
        logic [1:0] e_tnew, m_tnew;
        logic       e_we, m_we;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //          a1 a2 trs trt e_a3 m_a3 etn mtn ewe mwe exp
        vecs[0]  = '{8,  0, 0, 3, 8,  0,  2,  0,  1,  0,  1}; // load-use
        vecs[1]  = '{8,  0, 0, 3, 8,  0,  0,  0,  1,  0,  0}; // result ready
        vecs[2]  = '{0,  0, 0, 3, 0,  0,  2,  0,  1,  0,  0}; // $zero
        vecs[3]  = '{8,  0, 3, 3, 8,  0,  2,  0,  1,  0,  0}; // rs unused
        vecs[4]  = '{8,  0, 1, 3, 8,  0,  1,  0,  1,  0,  0}; // Tuse == Tnew
        vecs[5]  = '{8,  0, 0, 3, 8,  0,  1,  0,  1,  0,  1}; // Tuse < Tnew
        vecs[6]  = '{0,  9, 3, 0, 0,  9,  0,  1,  0,  1,  1}; // M-stage rt
        vecs[7]  = '{0,  9, 3, 0, 0,  9,  0,  1,  0,  0,  0}; // M not writing
        vecs[8]  = '{7,  0, 0, 3, 8,  7,  2,  0,  1,  0,  0}; // no match
        vecs[9]  = '{0, 12, 3, 1, 12, 0,  2,  0,  1,  0,  1}; // E-stage rt
        vecs[10] = '{5,  6, 0, 0, 5,  6,  2,  1,  1,  1,  1}; // both operands
        vecs[11] = '{4,  4, 2, 2, 4,  4,  2,  2,  1,  1,  0}; // Tuse 2 never waits

        reset_n = 1'b0;
        clear_inputs();
        #1;
        chk("reset stall",   32'(stall),   0);
        chk("reset md_busy", 32'(md_busy), 0);
        chk("reset hilo_we", 32'(hilo_we), 0);
        // Outputs stay low in reset even with a live hazard on the inputs.
        D_A1 = 8; D_Tuse_rs = 0; E_A3 = 8; E_Tnew = 2; E_WE = 1; D_is_md = 1; E_md_start = 1;
        #1;
        chk("reset gated stall",   32'(stall),   0);
        chk("reset gated flush_E", 32'(flush_E), 0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            D_A1 = vecs[i].a1; D_A2 = vecs[i].a2;
            D_Tuse_rs = vecs[i].tuse_rs; D_Tuse_rt = vecs[i].tuse_rt;
            E_A3 = vecs[i].e_a3; M_A3 = vecs[i].m_a3;
            E_Tnew = vecs[i].e_tnew; M_Tnew = vecs[i].m_tnew;
            E_WE = vecs[i].e_we; M_WE = vecs[i].m_we;
            #1;
            chk($sformatf("vec%0d stall", i),   32'(stall),   32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d flush_E", i), 32'(flush_E), 32'(vecs[i].exp_stall));
        end

        // Mult started at cycle 0: busy 1..5, hilo_we only at 5.
        do_reset();
        @(negedge clk);
        E_md_start = 1; E_md_div = 0;
        #1;
        chk("mul c0 md_busy", 32'(md_busy), 0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            E_md_start = 0;
            #1;
            chk($sformatf("mul c%0d md_busy", c), 32'(md_busy), 32'(c >= 1 && c <= 5));
            chk($sformatf("mul c%0d hilo_we", c), 32'(hilo_we), 32'(c == 5));
        end

        // Div with mfhi in D from cycle 0; simultaneous reg hazard at cycle 3.
        do_reset();
        @(negedge clk);
        E_md_start = 1; E_md_div = 1; D_is_md = 1;
        #1;
        chk("div c0 stall", 32'(stall), 1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            E_md_start = 0;
            if (c == 3) begin
                D_A1 = 8; D_Tuse_rs = 0; E_A3 = 8; E_Tnew = 2; E_WE = 1;
            end else begin
                D_A1 = 0; D_Tuse_rs = 3; E_WE = 0;
            end
            #1;
            chk($sformatf("div c%0d stall", c),   32'(stall),   32'(c <= 10));
            chk($sformatf("div c%0d hilo_we", c), 32'(hilo_we), 32'(c == 10));
        end

        // Reset asserted at cycle 4 of a div: immediate abort, no hilo_we ever.
        do_reset();
        @(negedge clk);
        E_md_start = 1; E_md_div = 1; D_is_md = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            E_md_start = 0;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst c4 md_busy", 32'(md_busy), 0);
        chk("rst c4 stall",   32'(stall),   0);
        @(negedge clk);
        reset_n = 1'b1;
        D_is_md = 0;
        for (int c = 6; c <= 14; c++) begin
            #1;
            chk($sformatf("rst c%0d hilo_we", c), 32'(hilo_we), 0);
            chk($sformatf("rst c%0d md_busy", c), 32'(md_busy), 0);
            @(negedge clk);
        end

`ifdef HAZARD_MD_STATS_EN
        do_reset();
        @(negedge clk);
        D_A1 = 8; D_Tuse_rs = 0; E_A3 = 8; E_Tnew = 2; E_WE = 1;
        repeat (7) @(negedge clk);
        clear_inputs();
        #1;
        chk("stall_cnt 7", stall_cnt, 32'd7);
`endif

        // Randomized traffic; register numbers kept small so hazards are common.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            D_A1 = 5'($urandom_range(0, 3));
            D_A2 = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3));
            D_Tuse_rt = 2'($urandom_range(0, 3));
            D_is_md = ($urandom_range(0, 3) == 0);
            E_A3 = 5'($urandom_range(0, 3));
            M_A3 = 5'($urandom_range(0, 3));
            E_Tnew = 2'($urandom_range(0, 3));
            M_Tnew = 2'($urandom_range(0, 3));
            E_WE = 1'($urandom_range(0, 1));
            M_WE = 1'($urandom_range(0, 1));
            E_md_start = ($urandom_range(0, 7) == 0);
            E_md_div = 1'($urandom_range(0, 1));
            #1;
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
